// File: rtl/grostl_round_sched_if.sv
// ---------------------------------------------------------------------------
// grostl_round_sched_if
//
// Purpose: Groups the control handshake and datapath-enable signals that
//          pass between the Groestl-512 round sequencer and its user.
//
// Parameters:
//   RND_W   width of the round-constant index
//
// Signals:
//   start, last_blk, abort       requests from the user to the sequencer
//   ready, done                  handshake status from the sequencer
//   ld_msg, pq_sel, rnd, rnd_en  round-unit control
//   p_we, q_we, cmb_en, out_xor  register write enables
//   trig                         scope trigger (optional feature)
//
// Modports:
//   master  the user side (drives requests, observes controls)
//   slave   the sequencer side
// ---------------------------------------------------------------------------
interface grostl_round_sched_if #(
  parameter int RND_W = 4
);
  logic             start;
  logic             last_blk;
  logic             abort;
  logic             ready;
  logic             ld_msg;
  logic             pq_sel;
  logic [RND_W-1:0] rnd;
  logic             rnd_en;
  logic             p_we;
  logic             q_we;
  logic             cmb_en;
  logic             out_xor;
  logic             done;
  logic             trig;

  modport master (
    output start, last_blk, abort,
    input  ready, ld_msg, pq_sel, rnd, rnd_en, p_we, q_we,
           cmb_en, out_xor, done, trig
  );

  modport slave (
    input  start, last_blk, abort,
    output ready, ld_msg, pq_sel, rnd, rnd_en, p_we, q_we,
           cmb_en, out_xor, done, trig
  );
endinterface

// File: rtl/grostl_round_sched.sv
// ---------------------------------------------------------------------------
// grostl_round_sched
//
// Purpose: Sequencer for the Groestl-512 compression datapath. A single
//          shared round unit alternates between the P and Q permutations
//          each round, computing f(h,m) = P(h^m) ^ Q(m) ^ h. On the final
//          block it additionally runs the output transform P(x) ^ x.
//
// Parameters:
//   NUM_ROUNDS  rounds per permutation (1..16)
//   RND_W       width of the round-constant index
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    grostl_round_sched_if.slave:
//            start/last_blk/abort in; ready, ld_msg, pq_sel, rnd, rnd_en,
//            p_we, q_we, cmb_en, out_xor, done, trig out
//
// All outputs are a Moore decode of state and round counter.
//
// Optional feature: define GROSTL_ROUND_SCHED_TRIGGER_EN to get a
// registered scope trigger that pulses one cycle after the first
// Q-permutation round. Without it, trig is tied low.
// ---------------------------------------------------------------------------
module grostl_round_sched #(
  parameter int NUM_ROUNDS = 14,
  parameter int RND_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  grostl_round_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RND_P,
    S_RND_Q,
    S_COMBINE,
    S_OUT_P,
    S_OUT_X,
    S_DONE
  } state_e;

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS - 1);

  state_e           state_q, state_d;
  logic [RND_W-1:0] cnt_q,   cnt_d;
  logic             last_q,  last_d;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its peers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every variable gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;

    // Abort overrides everything once busy; in IDLE it is a no-op so a
    // coincident start still launches a block.
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      last_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d = S_LOAD;
            cnt_d   = '0;
            last_d  = bus.last_blk;
          end
        end

        S_LOAD: begin
          state_d = S_RND_P;
          cnt_d   = '0;
        end

        S_RND_P: begin
          state_d = S_RND_Q;
        end

        // The round index advances only after Q, so P and Q share it.
        S_RND_Q: begin
          if (cnt_q == LAST_RND) begin
            state_d = S_COMBINE;
            cnt_d   = '0;
          end else begin
            state_d = S_RND_P;
            cnt_d   = cnt_q + RND_W'(1);
          end
        end

        S_COMBINE: begin
          state_d = last_q ? S_OUT_P : S_DONE;
        end

        S_OUT_P: begin
          if (cnt_q == LAST_RND) begin
            state_d = S_OUT_X;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + RND_W'(1);
          end
        end

        S_OUT_X: begin
          state_d = S_DONE;
        end

        S_DONE: begin
          state_d = S_IDLE;
          last_d  = 1'b0;
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          last_d  = 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Moore output decode
  // -------------------------------------------------------------------------
  always_comb begin
    bus.ready   = 1'b0;
    bus.ld_msg  = 1'b0;
    bus.pq_sel  = 1'b0;
    bus.rnd     = '0;
    bus.rnd_en  = 1'b0;
    bus.p_we    = 1'b0;
    bus.q_we    = 1'b0;
    bus.cmb_en  = 1'b0;
    bus.out_xor = 1'b0;
    bus.done    = 1'b0;

    unique case (state_q)
      S_IDLE:    bus.ready = 1'b1;
      S_LOAD:    bus.ld_msg = 1'b1;
      S_RND_P: begin
        bus.rnd_en = 1'b1;
        bus.p_we   = 1'b1;
        bus.rnd    = cnt_q;
      end
      S_RND_Q: begin
        bus.pq_sel = 1'b1;
        bus.rnd_en = 1'b1;
        bus.q_we   = 1'b1;
        bus.rnd    = cnt_q;
      end
      S_COMBINE: bus.cmb_en = 1'b1;
      // Output transform reuses the P path of the round unit.
      S_OUT_P: begin
        bus.rnd_en = 1'b1;
        bus.p_we   = 1'b1;
        bus.rnd    = cnt_q;
      end
      S_OUT_X:   bus.out_xor = 1'b1;
      S_DONE:    bus.done = 1'b1;
      default:   bus.ready = 1'b0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Optional scope trigger
  // -------------------------------------------------------------------------
`ifdef GROSTL_ROUND_SCHED_TRIGGER_EN
  logic trig_q, trig_d;

  // Marks the first Q round (the side-channel target), delayed one cycle;
  // an abort in that very cycle suppresses the pulse.
  always_comb begin
    trig_d = (state_q == S_RND_Q) && (cnt_q == '0) && !bus.abort;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q <= 1'b0;
    end else begin
      trig_q <= trig_d;
    end
  end

  assign bus.trig = trig_q;
`else
  assign bus.trig = 1'b0;
`endif

endmodule

// File: tb/tb_grostl_round_sched.sv
// ---------------------------------------------------------------------------
// tb_grostl_round_sched
//
// Purpose: Self-checking bench for grostl_round_sched. Expected output
//          vectors for every cycle are generated from the intended
//          schedule and queued when a block is launched; each cycle one
//          entry is popped and compared against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_grostl_round_sched;

  localparam int NR    = 14;
  localparam int RND_W = 4;

`ifdef GROSTL_ROUND_SCHED_TRIGGER_EN
  localparam bit TRIG_ON = 1'b1;
`else
  localparam bit TRIG_ON = 1'b0;
`endif

  typedef struct packed {
    logic             ready;
    logic             ld_msg;
    logic             pq_sel;
    logic [RND_W-1:0] rnd;
    logic             rnd_en;
    logic             p_we;
    logic             q_we;
    logic             cmb_en;
    logic             out_xor;
    logic             done;
    logic             trig;
  } outs_t;

  logic clk;
  logic rst_n;

  grostl_round_sched_if #(.RND_W(RND_W)) bus ();

  grostl_round_sched #(
    .NUM_ROUNDS (NR),
    .RND_W      (RND_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  outs_t sb_q[$];
  outs_t gen_q[$];
  outs_t idle_v;

  function automatic outs_t obs();
    outs_t o;
    o.ready   = bus.ready;
    o.ld_msg  = bus.ld_msg;
    o.pq_sel  = bus.pq_sel;
    o.rnd     = bus.rnd;
    o.rnd_en  = bus.rnd_en;
    o.p_we    = bus.p_we;
    o.q_we    = bus.q_we;
    o.cmb_en  = bus.cmb_en;
    o.out_xor = bus.out_xor;
    o.done    = bus.done;
    o.trig    = bus.trig;
    return o;
  endfunction

  task automatic check(input string tag, input outs_t got, input outs_t exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got rdy=%b ld=%b pq=%b rnd=%0d en=%b pwe=%b qwe=%b cmb=%b ox=%b dn=%b tr=%b, expected rdy=%b ld=%b pq=%b rnd=%0d en=%b pwe=%b qwe=%b cmb=%b ox=%b dn=%b tr=%b",
               tag, got.ready, got.ld_msg, got.pq_sel, got.rnd, got.rnd_en,
               got.p_we, got.q_we, got.cmb_en, got.out_xor, got.done, got.trig,
               exp.ready, exp.ld_msg, exp.pq_sel, exp.rnd, exp.rnd_en,
               exp.p_we, exp.q_we, exp.cmb_en, exp.out_xor, exp.done, exp.trig);
    end
  endtask

  // Builds the per-cycle expectation of one block, starting with LOAD.
  task automatic gen_block(input bit last);
    outs_t e;
    gen_q.delete();
    e = '0; e.ld_msg = 1'b1; gen_q.push_back(e);
    for (int r = 0; r < NR; r++) begin
      e = '0; e.rnd = RND_W'(r); e.rnd_en = 1'b1; e.p_we = 1'b1;
      gen_q.push_back(e);
      e = '0; e.rnd = RND_W'(r); e.rnd_en = 1'b1; e.q_we = 1'b1; e.pq_sel = 1'b1;
      gen_q.push_back(e);
    end
    e = '0; e.cmb_en = 1'b1; gen_q.push_back(e);
    if (last) begin
      for (int r = 0; r < NR; r++) begin
        e = '0; e.rnd = RND_W'(r); e.rnd_en = 1'b1; e.p_we = 1'b1;
        gen_q.push_back(e);
      end
      e = '0; e.out_xor = 1'b1; gen_q.push_back(e);
    end
    e = '0; e.done = 1'b1; gen_q.push_back(e);
    if (TRIG_ON) begin
      for (int i = 0; i + 1 < gen_q.size(); i++) begin
        if (gen_q[i].q_we && gen_q[i].rnd == '0) begin
          e = gen_q[i+1];
          e.trig = 1'b1;
          gen_q[i+1] = e;
        end
      end
    end
  endtask

  task automatic push_gen(input int count);
    for (int i = 0; i < count && i < gen_q.size(); i++) sb_q.push_back(gen_q[i]);
  endtask

  task automatic cycle_check();
    outs_t exp;
    @(negedge clk);
    cyc++;
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : idle_v;
    check($sformatf("cyc%0d", cyc), obs(), exp);
  endtask

  // Launches one block from IDLE, toggles start/last_blk while busy to
  // prove they are ignored, and checks through the following ready cycle.
  task automatic run_block(input bit last);
    bus.start    = 1'b1;
    bus.last_blk = last;
    gen_block(last);
    push_gen(gen_q.size());
    sb_q.push_back(idle_v);
    for (int k = 0; sb_q.size() > 0; k++) begin
      cycle_check();
      if (k == 0) begin
        bus.start    = 1'b0;
        bus.last_blk = ~last;
      end
      if (k == 4) bus.start = 1'b1;
      if (k == 5) bus.start = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle_v       = '0;
    idle_v.ready = 1'b1;

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.last_blk = 1'b0;
    bus.abort    = 1'b0;
    repeat (2) @(negedge clk);
    check("reset", obs(), idle_v);
    rst_n = 1'b1;
    repeat (2) cycle_check();

    // Non-final and final blocks.
    run_block(1'b0);
    run_block(1'b1);

    // start held high: blk0 (non-final), ready, blk1 (final).
    bus.start    = 1'b1;
    bus.last_blk = 1'b0;
    gen_block(1'b0);
    push_gen(gen_q.size());
    sb_q.push_back(idle_v);
    gen_block(1'b1);
    push_gen(gen_q.size());
    for (int k = 0; sb_q.size() > 0; k++) begin
      cycle_check();
      if (k == 0) bus.last_blk = 1'b1;
    end
    bus.start    = 1'b0;
    bus.last_blk = 1'b0;
    sb_q.push_back(idle_v);
    while (sb_q.size() > 0) cycle_check();

    // Abort at cycle 10, then several idle cycles with no enables.
    bus.start    = 1'b1;
    bus.last_blk = 1'b1;
    gen_block(1'b1);
    push_gen(10);
    for (int k = 0; sb_q.size() > 0; k++) begin
      cycle_check();
      if (k == 0) bus.start = 1'b0;
    end
    bus.abort = 1'b1;
    repeat (3) sb_q.push_back(idle_v);
    while (sb_q.size() > 0) cycle_check();

    // abort together with start in IDLE: start wins. The earlier abort
    // also cleared last_r, so a non-final launch must not run OUT_P.
    bus.start    = 1'b1;
    bus.last_blk = 1'b0;
    gen_block(1'b0);
    push_gen(gen_q.size());
    sb_q.push_back(idle_v);
    for (int k = 0; sb_q.size() > 0; k++) begin
      cycle_check();
      if (k == 0) begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
      end
    end

    // Async reset mid final-block run at cycle 35.
    bus.start    = 1'b1;
    bus.last_blk = 1'b1;
    gen_block(1'b1);
    push_gen(35);
    for (int k = 0; sb_q.size() > 0; k++) begin
      cycle_check();
      if (k == 0) bus.start = 1'b0;
    end
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst", obs(), idle_v);
    sb_q.delete();
    cycle_check();
    rst_n = 1'b1;
    cycle_check();
    run_block(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
